// File: rtl/rptr_pkg.sv
// Shared FIFO pointer geometry and Gray helper for the read- and write-side handlers.
package rptr_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned PTR_W  = 9;
  localparam int unsigned DEPTH  = 256;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: bit i is the XOR of all Gray bits at or above i.
module gray2bin #(
  parameter int unsigned W = rptr_pkg::PTR_W
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/rptr_handler.sv
// Async FIFO read-side pointer/flag handler. Define RPTR_FWFT_EN for first-word-fall-through
// output mode; otherwise data follows a granted read by one cycle.
module rptr_handler
  import rptr_pkg::*;
#(
  parameter int unsigned AE_THRESH = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             ren,
  input  logic [PTR_W-1:0] wptr_gray_async,
  output logic [PTR_W-1:0] rptr_bin,
  output logic [PTR_W-1:0] rptr_gray,
  output logic             mem_ren,
  output logic             rvalid,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR_W-1:0] rd_level
);

  logic [PTR_W-1:0] wq1_q, wq2_q;
  logic [PTR_W-1:0] rptr_bin_q, rptr_bin_d;
  logic [PTR_W-1:0] rptr_gray_q, rptr_gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             ae_q, ae_d;
  logic             rvalid_q, rvalid_d;
  logic             pop;
  logic [PTR_W-1:0] wbin_sync;

  gray2bin #(.W(PTR_W)) u_gray2bin (
    .gray_i (wq2_q),
    .bin_o  (wbin_sync)
  );

  // Pop is gated by reset so a request pending at reset never reaches memory.
  always_comb begin
`ifdef RPTR_FWFT_EN
    pop      = rrst_n & ~empty_q & (~rvalid_q | ren);
    rvalid_d = rvalid_q;
    if (pop) begin
      rvalid_d = 1'b1;
    end else if (ren) begin
      rvalid_d = 1'b0;
    end
`else
    pop      = rrst_n & ren & ~empty_q;
    rvalid_d = pop;
`endif
  end

  always_comb begin
    rptr_bin_d  = rptr_bin_q + PTR_W'(pop);
    rptr_gray_d = bin2gray(rptr_bin_d);
    empty_d     = (rptr_gray_d == wq2_q);
    level_d     = wbin_sync - rptr_bin_d;
    ae_d        = (32'(level_d) <= AE_THRESH);
  end

  // Two-flop synchronizer: nothing but the flops between the async input and wq2.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= wptr_gray_async;
      wq2_q <= wq1_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      rvalid_q    <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign mem_ren      = pop;
  assign rptr_bin     = rptr_bin_q;
  assign rptr_gray    = rptr_gray_q;
  assign rd_level     = level_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_rptr_handler.sv
// Self-checking bench for rptr_handler: directed scenarios plus randomized traffic against a count-based model.
module tb_rptr_handler;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       ren;
  logic [8:0] wptr_gray_async;
  logic [8:0] rptr_bin, rptr_gray, rd_level;
  logic       mem_ren, rvalid, empty, almost_empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: writer/reader positions as plain integers mod 512.
  int m_w, m_wq1, m_wq2, m_r, m_level;
  bit m_rst, m_empty, m_ae, m_rvalid, exp_pop;

  rptr_handler #(.AE_THRESH(4)) dut (
    .rclk            (rclk),
    .rrst_n          (rrst_n),
    .ren             (ren),
    .wptr_gray_async (wptr_gray_async),
    .rptr_bin        (rptr_bin),
    .rptr_gray       (rptr_gray),
    .mem_ren         (mem_ren),
    .rvalid          (rvalid),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .rd_level        (rd_level)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 511;
  endfunction

  task automatic drive(input bit rst_v, input bit ren_v, input int w_v);
    rrst_n = rst_v;
    ren    = ren_v;
    m_rst  = rst_v;
    m_w    = w_v & 511;
    wptr_gray_async = 9'(gray(m_w));
    #2;
`ifdef RPTR_FWFT_EN
    exp_pop = rst_v && !m_empty && (!m_rvalid || ren_v);
`else
    exp_pop = rst_v && ren_v && !m_empty;
`endif
  endtask

  task automatic tick();
    int r_next;
    @(posedge rclk);
    if (!m_rst) begin
      m_wq1 = 0; m_wq2 = 0; m_r = 0; m_level = 0;
      m_empty = 1; m_ae = 1; m_rvalid = 0;
    end else begin
      r_next  = (m_r + (exp_pop ? 1 : 0)) & 511;
      m_empty = (r_next == m_wq2);
      m_level = (m_wq2 - r_next) & 511;
      m_ae    = (m_level <= 4);
`ifdef RPTR_FWFT_EN
      if (exp_pop) m_rvalid = 1;
      else if (ren) m_rvalid = 0;
`else
      m_rvalid = exp_pop;
`endif
      m_r   = r_next;
      m_wq2 = m_wq1;
      m_wq1 = m_w;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0); tick();
    drive(0, 1, 0);
    n_checks++;
    if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL reset_memren: got %b want 0", mem_ren); end
    tick();
    n_checks++;
    if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++;
    if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    n_checks++;
    if (rd_level !== 9'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", rd_level); end
    n_checks++;
    if (rptr_gray !== 9'd0) begin n_errors++; $display("FAIL reset_gray: got %0h want 0", rptr_gray); end
    n_checks++;
    if (rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0);
      n_checks++;
      if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL empty_read_memren: cycle %0d got %b want 0", i, mem_ren); end
      tick();
      n_checks++;
      if (rptr_bin !== 9'd0) begin n_errors++; $display("FAIL empty_read_rptr: cycle %0d got %0d want 0", i, rptr_bin); end
    end
    drive(1, 0, 0);
  endtask

  task automatic test_write_visibility();
    drive(1, 0, 1);
    tick();
    n_checks++;
    if (empty !== 1'b1) begin n_errors++; $display("FAIL vis_edge1: empty got %b want 1", empty); end
    tick();
    n_checks++;
    if (empty !== 1'b1) begin n_errors++; $display("FAIL vis_edge2: empty got %b want 1", empty); end
    tick();
    n_checks++;
    if (empty !== 1'b0 || rd_level !== 9'd1) begin
      n_errors++; $display("FAIL vis_edge3: empty/level got %b/%0d want 0/1", empty, rd_level);
    end
    drive(1, 1, 1);
    n_checks++;
    if (mem_ren !== 1'b1) begin n_errors++; $display("FAIL vis_pop: mem_ren got %b want 1", mem_ren); end
    tick();
    drive(1, 0, 1);
    n_checks++;
    if (rptr_bin !== 9'd1 || empty !== 1'b1 || rvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL vis_after_pop: rptr/empty/rvalid got %0d/%b/%b want 1/1/1", rptr_bin, empty, rvalid);
    end
    tick();
    n_checks++;
    if (rvalid !== 1'b0) begin n_errors++; $display("FAIL vis_rvalid_drop: got %b want 0", rvalid); end
  endtask

  task automatic test_wrap();
    int exp_seq[4] = '{511, 0, 1, 2};
    int guard;
    for (int w = m_w + 1; w <= 510; w++) begin
      drive(1, 1, w); tick();
    end
    guard = 0;
    while (m_r != 510 && guard < 20) begin
      drive(1, 1, 510); tick(); guard++;
    end
    drive(1, 0, 510); tick();
    n_checks++;
    if (rptr_bin !== 9'd510 || empty !== 1'b1) begin
      n_errors++; $display("FAIL wrap_preload: rptr/empty got %0d/%b want 510/1", rptr_bin, empty);
    end
    drive(1, 0, 2);
    guard = 0;
    while (empty !== 1'b0 && guard < 10) begin tick(); guard++; end
    n_checks++;
    if (empty !== 1'b0 || rd_level !== 9'd4) begin
      n_errors++; $display("FAIL wrap_fill: empty/level got %b/%0d want 0/4", empty, rd_level);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 2);
      n_checks++;
      if (mem_ren !== 1'b1) begin n_errors++; $display("FAIL wrap_memren: pop %0d got %b want 1", k, mem_ren); end
      tick();
      n_checks++;
      if (32'(rptr_bin) !== exp_seq[k] || 32'(rptr_gray) !== gray(exp_seq[k])) begin
        n_errors++;
        $display("FAIL wrap_seq: pop %0d bin/gray got %0d/%0h want %0d/%0h", k, rptr_bin, rptr_gray,
                 exp_seq[k], gray(exp_seq[k]));
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin n_errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    drive(1, 0, 2); tick();
  endtask

  task automatic test_almost_empty();
    drive(1, 0, 8);
    tick(); tick(); tick();
    n_checks++;
    if (rd_level !== 9'd6 || almost_empty !== 1'b0) begin
      n_errors++; $display("FAIL ae_level6: level/ae got %0d/%b want 6/0", rd_level, almost_empty);
    end
    drive(1, 1, 8); tick();
    n_checks++;
    if (rd_level !== 9'd5 || almost_empty !== 1'b0) begin
      n_errors++; $display("FAIL ae_level5: level/ae got %0d/%b want 5/0", rd_level, almost_empty);
    end
    drive(1, 1, 8); tick();
    n_checks++;
    if (rd_level !== 9'd4 || almost_empty !== 1'b1 || rptr_bin !== 9'd4) begin
      n_errors++;
      $display("FAIL ae_level4: level/ae/rptr got %0d/%b/%0d want 4/1/4", rd_level, almost_empty, rptr_bin);
    end
    drive(1, 0, 8); tick();
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 0, 14);
    tick(); tick(); tick();
    n_checks++;
    if (rd_level !== 9'd10) begin n_errors++; $display("FAIL midrst_level: got %0d want 10", rd_level); end
    drive(0, 1, 14);
    n_checks++;
    if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL midrst_memren: got %b want 0", mem_ren); end
    tick();
    n_checks++;
    if (rptr_bin !== 9'd0 || rptr_gray !== 9'd0 || rd_level !== 9'd0 || empty !== 1'b1 ||
        almost_empty !== 1'b1 || rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_outputs: bin=%0d gray=%0h lvl=%0d empty=%b ae=%b rvalid=%b want 0/0/0/1/1/0",
               rptr_bin, rptr_gray, rd_level, empty, almost_empty, rvalid);
    end
    drive(1, 1, 14);
    n_checks++;
    if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL midrst_no_extra_pop: got %b want 0", mem_ren); end
    tick();
    drive(0, 0, 0); tick(); tick();
    drive(1, 0, 0);
  endtask

`ifdef RPTR_FWFT_EN
  task automatic test_fwft();
    int guard = 0;
    drive(1, 0, 1);
    while (empty !== 1'b0 && guard < 10) begin tick(); guard++; end
    n_checks++;
    if (empty !== 1'b0) begin n_errors++; $display("FAIL fwft_empty_fall: got %b want 0", empty); end
    n_checks++;
    if (mem_ren !== 1'b1) begin n_errors++; $display("FAIL fwft_autopop: got %b want 1", mem_ren); end
    tick();
    n_checks++;
    if (rvalid !== 1'b1) begin n_errors++; $display("FAIL fwft_rvalid_set: got %b want 1", rvalid); end
    drive(1, 1, 1); tick();
    n_checks++;
    if (rvalid !== 1'b0) begin n_errors++; $display("FAIL fwft_rvalid_ack: got %b want 0", rvalid); end
    drive(1, 0, 1); tick();
  endtask
`endif

  task automatic test_random();
    int w;
    bit r_v, rst_v;
    w = m_w;
    for (int i = 0; i < 600; i++) begin
      rst_v = ($urandom_range(0, 149) != 0);
      r_v   = ($urandom_range(0, 2) != 0);
      if (!rst_v) w = 0;
      else if ($urandom_range(0, 1) == 1 && ((w - m_r) & 511) < 256) w = (w + 1) & 511;
      drive(rst_v, r_v, w);
      n_checks++;
      if (mem_ren !== exp_pop) begin
        n_errors++; $display("FAIL rand_memren: cycle %0d got %b want %b", i, mem_ren, exp_pop);
      end
      tick();
      n_checks++;
      if (32'(rptr_bin) !== m_r || 32'(rptr_gray) !== gray(m_r) || 32'(rd_level) !== m_level ||
          empty !== m_empty || almost_empty !== m_ae || rvalid !== m_rvalid) begin
        n_errors++;
        $display("FAIL rand_state: cycle %0d got bin=%0d gray=%0h lvl=%0d e=%b ae=%b v=%b want %0d/%0h/%0d/%b/%b/%b",
                 i, rptr_bin, rptr_gray, rd_level, empty, almost_empty, rvalid,
                 m_r, gray(m_r), m_level, m_empty, m_ae, m_rvalid);
      end
    end
  endtask

  initial begin
    m_w = 0; m_wq1 = 0; m_wq2 = 0; m_r = 0; m_level = 0;
    m_empty = 1; m_ae = 1; m_rvalid = 0; m_rst = 0; exp_pop = 0;
    test_reset();
`ifdef RPTR_FWFT_EN
    test_fwft();
`else
    test_write_visibility();
    test_wrap();
    test_almost_empty();
    test_reset_mid_burst();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
